// File: rtl/forward_if.sv
// Stream-side bundle of the forward 3D convolution engine: weight and input
// load strobes, the reload request, and the result handshake.
interface forward_if;
  logic        weight_valid;
  logic [31:0] weight_data;
  logic        weight_reload;
  logic        valid_in;
  logic [31:0] input_data;
  logic        in_ready;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] output_data;
  logic        out_last;

  // Producer / consumer side (the stream source and result sink).
  modport master (
    output weight_valid,
    output weight_data,
    output weight_reload,
    output valid_in,
    output input_data,
    input  in_ready,
    input  valid_out,
    output ready_out,
    input  output_data,
    input  out_last
  );

  // Engine side.
  modport slave (
    input  weight_valid,
    input  weight_data,
    input  weight_reload,
    input  valid_in,
    input  input_data,
    output in_ready,
    output valid_out,
    input  ready_out,
    output output_data,
    output out_last
  );
endinterface

// File: rtl/forward.sv
// Forward (direct) valid-mode strided 3D convolution, single channel, no bias.
// Loads a KD x KH x KW kernel and a D x H x W volume, then computes each output
// with one serial multiply-accumulate per cycle and streams saturated results.
module forward #(
  parameter int D  = 4,
  parameter int H  = 4,
  parameter int W  = 5,
  parameter int KD = 2,
  parameter int KH = 3,
  parameter int KW = 2,
  parameter int SD = 1,
  parameter int SH = 1,
  parameter int SW = 2
) (
  input logic     clk,
  input logic     rst_n,
  forward_if.slave bus
);

  localparam int OD  = (D - KD) / SD + 1;
  localparam int OH  = (H - KH) / SH + 1;
  localparam int OW  = (W - KW) / SW + 1;
  localparam int KT  = KD * KH * KW;
  localparam int NX  = D * H * W;

  localparam int TA  = (KT > 1) ? $clog2(KT) : 1;
  localparam int XA  = (NX > 1) ? $clog2(NX) : 1;
  localparam int KDW = (KD > 1) ? $clog2(KD) : 1;
  localparam int KHW = (KH > 1) ? $clog2(KH) : 1;
  localparam int KWW = (KW > 1) ? $clog2(KW) : 1;
  localparam int ODW = (OD > 1) ? $clog2(OD) : 1;
  localparam int OHW = (OH > 1) ? $clog2(OH) : 1;
  localparam int OWW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic signed [39:0] SAT_MAX = 40'sh007FFFFFFF;
  localparam logic signed [39:0] SAT_MIN = 40'shFF80000000;

  typedef enum logic [1:0] {
    W_LOAD = 2'd0,
    X_LOAD = 2'd1,
    MAC    = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TA-1:0]  wcnt_q, wcnt_d;
  logic [XA-1:0]  xcnt_q, xcnt_d;
  logic [TA-1:0]  tap_q,  tap_d;
  logic [KDW-1:0] kd_q,   kd_d;
  logic [KHW-1:0] kh_q,   kh_d;
  logic [KWW-1:0] kw_q,   kw_d;
  logic [ODW-1:0] od_q,   od_d;
  logic [OHW-1:0] oh_q,   oh_d;
  logic [OWW-1:0] ow_q,   ow_d;
  logic signed [39:0] acc_q, acc_d;

  // Kernel and volume storage; contents are deliberately not reset.
  logic signed [15:0] wmem [KT];
  logic signed [15:0] xmem [NX];

  logic               w_we;
  logic               x_we;
  logic               reload_take;
  logic               last_tap;
  logic               last_pos;
  logic [XA-1:0]      x_addr;
  logic signed [15:0] w_rd;
  logic signed [15:0] x_rd;
  logic signed [31:0] prod;
  logic [31:0]        sat_data;
  logic               unused_hi;

  // The upper half of each stream word carries no information for this block.
  assign unused_hi = ^{bus.weight_data[31:16], bus.input_data[31:16]};

  // A reload request only counts before the first sample of a volume arrives;
  // it wins over a sample strobe presented in the same cycle.
  assign reload_take = (state_q == X_LOAD) && bus.weight_reload && (xcnt_q == '0);
  assign w_we        = (state_q == W_LOAD) && bus.weight_valid;
  assign x_we        = (state_q == X_LOAD) && bus.valid_in && !reload_take;

  assign last_tap = (tap_q == TA'(KT - 1));
  assign last_pos = (od_q == ODW'(OD - 1)) && (oh_q == OHW'(OH - 1)) &&
                    (ow_q == OWW'(OW - 1));

  // Raster address of the input sample under the current kernel tap.
  assign x_addr = XA'((int'(od_q) * SD + int'(kd_q)) * (H * W) +
                      (int'(oh_q) * SH + int'(kh_q)) * W +
                      int'(ow_q) * SW + int'(kw_q));

  assign w_rd = wmem[tap_q];
  assign x_rd = xmem[x_addr];
  assign prod = 32'(w_rd) * 32'(x_rd);

  // Kernel tap write port.
  always_ff @(posedge clk) begin
    if (w_we) begin
      wmem[wcnt_q] <= bus.weight_data[15:0];
    end
  end

  // Input sample write port.
  always_ff @(posedge clk) begin
    if (x_we) begin
      xmem[xcnt_q] <= bus.input_data[15:0];
    end
  end

  // State, counter and accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= W_LOAD;
      wcnt_q  <= '0;
      xcnt_q  <= '0;
      tap_q   <= '0;
      kd_q    <= '0;
      kh_q    <= '0;
      kw_q    <= '0;
      od_q    <= '0;
      oh_q    <= '0;
      ow_q    <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      xcnt_q  <= xcnt_d;
      tap_q   <= tap_d;
      kd_q    <= kd_d;
      kh_q    <= kh_d;
      kw_q    <= kw_d;
      od_q    <= od_d;
      oh_q    <= oh_d;
      ow_q    <= ow_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state logic: load sequencing, kernel walk, output walk.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    xcnt_d  = xcnt_q;
    tap_d   = tap_q;
    kd_d    = kd_q;
    kh_d    = kh_q;
    kw_d    = kw_q;
    od_d    = od_q;
    oh_d    = oh_q;
    ow_d    = ow_q;
    acc_d   = acc_q;

    case (state_q)
      W_LOAD: begin
        if (bus.weight_valid) begin
          if (wcnt_q == TA'(KT - 1)) begin
            wcnt_d  = '0;
            state_d = X_LOAD;
          end else begin
            wcnt_d = wcnt_q + TA'(1);
          end
        end
      end

      X_LOAD: begin
        if (reload_take) begin
          wcnt_d  = '0;
          state_d = W_LOAD;
        end else if (bus.valid_in) begin
          if (xcnt_q == XA'(NX - 1)) begin
            xcnt_d  = '0;
            tap_d   = '0;
            kd_d    = '0;
            kh_d    = '0;
            kw_d    = '0;
            acc_d   = '0;
            state_d = MAC;
          end else begin
            xcnt_d = xcnt_q + XA'(1);
          end
        end
      end

      MAC: begin
        acc_d = acc_q + {{8{prod[31]}}, prod};
        if (last_tap) begin
          tap_d   = '0;
          kd_d    = '0;
          kh_d    = '0;
          kw_d    = '0;
          state_d = EMIT;
        end else begin
          tap_d = tap_q + TA'(1);
          if (kw_q == KWW'(KW - 1)) begin
            kw_d = '0;
            if (kh_q == KHW'(KH - 1)) begin
              kh_d = '0;
              kd_d = kd_q + KDW'(1);
            end else begin
              kh_d = kh_q + KHW'(1);
            end
          end else begin
            kw_d = kw_q + KWW'(1);
          end
        end
      end

      EMIT: begin
        if (bus.ready_out) begin
          if (last_pos) begin
            od_d    = '0;
            oh_d    = '0;
            ow_d    = '0;
            xcnt_d  = '0;
            state_d = X_LOAD;
          end else begin
            acc_d   = '0;
            state_d = MAC;
            if (ow_q == OWW'(OW - 1)) begin
              ow_d = '0;
              if (oh_q == OHW'(OH - 1)) begin
                oh_d = '0;
                od_d = od_q + ODW'(1);
              end else begin
                oh_d = oh_q + OHW'(1);
              end
            end else begin
              ow_d = ow_q + OWW'(1);
            end
          end
        end
      end

      default: begin
        state_d = W_LOAD;
      end
    endcase
  end

  // Clamp the 40-bit accumulator into the signed 32-bit result range.
  always_comb begin
    sat_data = acc_q[31:0];
    if (acc_q > SAT_MAX) begin
      sat_data = 32'h7FFF_FFFF;
    end else if (acc_q < SAT_MIN) begin
      sat_data = 32'h8000_0000;
    end
  end

  // Result stays stable through EMIT because the accumulator only moves in MAC.
  assign bus.in_ready    = (state_q == W_LOAD) || (state_q == X_LOAD);
  assign bus.valid_out   = (state_q == EMIT);
  assign bus.out_last    = (state_q == EMIT) && last_pos;
  assign bus.output_data = sat_data;

endmodule

// File: tb/tb_forward.sv
// Bench for the forward 3D convolution engine: directed volumes checked
// against a loop-nest convolution model, plus hand-computed pins.
module tb_forward;
  localparam int D  = 4, H  = 4, W  = 5;
  localparam int KD = 2, KH = 3, KW = 2;
  localparam int SD = 1, SH = 1, SW = 2;
  localparam int OD = (D - KD) / SD + 1;
  localparam int OH = (H - KH) / SH + 1;
  localparam int OW = (W - KW) / SW + 1;
  localparam int KT = KD * KH * KW;
  localparam int NO = OD * OH * OW;
  localparam int NX = D * H * W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  forward_if bus ();
  forward dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_edge = 0;
  int n_out_vol = 0;
  int n_last_vol = 0;
  int last_lat = 0;
  bit prev_valid = 1'b0;
  logic [32:0] exp_q[$];
  logic signed [15:0] w_m [KT];
  logic signed [15:0] x_m [NX];
  int id_exp [12] = '{0, 2, 5, 7, 20, 22, 25, 27, 40, 42, 45, 47};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got %0h need %0h", name, got, need);
    end
  endtask

  // Direct convolution from the arithmetic definition.
  function automatic logic [31:0] conv_at(input int od, input int oh, input int ow);
    longint acc = 0;
    for (int kd = 0; kd < KD; kd++)
      for (int kh = 0; kh < KH; kh++)
        for (int kw = 0; kw < KW; kw++)
          acc += longint'(x_m[((od*SD + kd)*H + (oh*SH + kh))*W + ow*SW + kw]) *
                 longint'(w_m[(kd*KH + kh)*KW + kw]);
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  task automatic build_expected();
    int idx = 0;
    exp_q.delete();
    for (int od = 0; od < OD; od++)
      for (int oh = 0; oh < OH; oh++)
        for (int ow = 0; ow < OW; ow++) begin
          exp_q.push_back({(idx == NO - 1), conv_at(od, oh, ow)});
          idx++;
        end
  endtask

  // Per-cycle compare: data/last against the model, and output timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.valid_out) begin
        if (!prev_valid) begin
          last_lat = cyc + 1 - ref_edge;
          check("out_timing", 64'(last_lat), 64'(KT + 1));
        end
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(bus.valid_out), 64'd0);
        end else begin
          check("out_word", {31'd0, bus.out_last, bus.output_data}, {31'd0, exp_q[0]});
          if (bus.ready_out) begin
            void'(exp_q.pop_front());
            n_out_vol++;
            if (bus.out_last) n_last_vol++;
            else ref_edge = cyc + 1;
          end
        end
      end
      prev_valid = bus.valid_out;
    end
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic load_w();
    for (int k = 0; k < KT; k++) begin
      bus.weight_valid = 1'b1;
      bus.weight_data  = {16'hDEAD, w_m[k]};
      bus.valid_in     = 1'b1;
      bus.input_data   = 32'h0000_5A5A;
      @(posedge clk); #1;
    end
    bus.weight_valid = 1'b0;
    bus.valid_in     = 1'b0;
  endtask

  task automatic load_x(input int reload_at);
    build_expected();
    n_out_vol  = 0;
    n_last_vol = 0;
    for (int i = 0; i < NX; i++) begin
      bus.valid_in      = 1'b1;
      bus.input_data    = {16'hBEEF, x_m[i]};
      bus.weight_valid  = 1'b1;
      bus.weight_data   = 32'h0000_1111;
      bus.weight_reload = (i == reload_at);
      if (i == NX - 1) begin
        @(negedge clk);
        ref_edge = cyc + 1;
      end
      @(posedge clk); #1;
    end
    bus.valid_in      = 1'b0;
    bus.weight_valid  = 1'b0;
    bus.weight_reload = 1'b0;
    check("in_ready_after_load", 64'(bus.in_ready), 64'd0);
  endtask

  task automatic wait_outputs(input int target, input int stall_idx);
    int budget = 4000;
    int stall_left = -1;
    while (n_out_vol < target && budget > 0) begin
      if (stall_idx >= 0 && n_out_vol == stall_idx && bus.valid_out && stall_left < 0)
        stall_left = 5;
      if (stall_left > 0) begin
        bus.ready_out = 1'b0;
        stall_left--;
      end else begin
        bus.ready_out = 1'b1;
      end
      @(posedge clk); #1;
      budget--;
    end
    bus.ready_out = 1'b1;
    check("output_timeout", 64'(n_out_vol >= target), 64'd1);
  endtask

  task automatic finish_volume();
    check("outputs_per_volume", 64'(n_out_vol), 64'(NO));
    check("last_per_volume", 64'(n_last_vol), 64'd1);
    check("in_ready_after_volume", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic pulse_reload();
    bus.weight_reload = 1'b1;
    @(posedge clk); #1;
    bus.weight_reload = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.weight_valid  = 1'b0;
    bus.weight_data   = '0;
    bus.weight_reload = 1'b0;
    bus.valid_in      = 1'b0;
    bus.input_data    = '0;
    bus.ready_out     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(bus.valid_out), 64'd0);
    check("rst_output_data", 64'(bus.output_data), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All-ones kernel and volume.
    foreach (w_m[k]) w_m[k] = 16'sd1;
    foreach (x_m[i]) x_m[i] = 16'sd1;
    load_w();
    load_x(-1);
    check("model_ones", 64'(exp_q[0][31:0]), 64'd12);
    wait_outputs(NO, -1);
    finish_volume();
    $display("volume ones: outputs %0d latency %0d", n_out_vol, last_lat);

    // Retained kernel, signed pattern, late reload ignored, backpressure.
    foreach (x_m[i]) x_m[i] = 16'(((i * 7) % 23) - 11);
    load_x(3);
    wait_outputs(NO, 4);
    finish_volume();
    $display("volume reuse: outputs %0d", n_out_vol);

    // Reload to identity kernel, ramp input.
    pulse_reload();
    foreach (w_m[k]) w_m[k] = (k == 0) ? 16'sd1 : 16'sd0;
    load_w();
    foreach (x_m[i]) x_m[i] = 16'(i);
    load_x(-1);
    for (int i = 0; i < NO; i++)
      check("model_identity", 64'(exp_q[i][31:0]), 64'(id_exp[i]));
    wait_outputs(NO, -1);
    finish_volume();
    $display("volume identity: outputs %0d", n_out_vol);

    // Reload to all-2 kernel.
    pulse_reload();
    foreach (w_m[k]) w_m[k] = 16'sd2;
    load_w();
    foreach (x_m[i]) x_m[i] = 16'sd1;
    load_x(-1);
    check("model_twos", 64'(exp_q[0][31:0]), 64'd24);
    wait_outputs(NO, -1);
    finish_volume();
    $display("volume twos: outputs %0d", n_out_vol);

    // Positive saturation.
    pulse_reload();
    foreach (w_m[k]) w_m[k] = 16'sh7FFF;
    load_w();
    foreach (x_m[i]) x_m[i] = 16'sh7FFF;
    load_x(-1);
    check("model_sat_pos", 64'(exp_q[0][31:0]), 64'h7FFF_FFFF);
    wait_outputs(NO, -1);
    finish_volume();
    $display("volume sat_pos: outputs %0d", n_out_vol);

    // Negative saturation with retained kernel.
    foreach (x_m[i]) x_m[i] = 16'sh8000;
    load_x(-1);
    check("model_sat_neg", 64'(exp_q[0][31:0]), 64'h8000_0000);
    wait_outputs(NO, -1);
    finish_volume();
    $display("volume sat_neg: outputs %0d", n_out_vol);

    // Reset during the third output's accumulation, then full reload.
    pulse_reload();
    foreach (w_m[k]) w_m[k] = 16'sd1;
    load_w();
    foreach (x_m[i]) x_m[i] = 16'sd1;
    load_x(-1);
    wait_outputs(2, -1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", 64'(bus.valid_out), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_last", 64'(bus.out_last), 64'd0);
    exp_q.delete();
    n_out_vol  = 0;
    n_last_vol = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_w();
    load_x(-1);
    check("model_after_reset", 64'(exp_q[NO-1][32:0]), {31'd0, 1'b1, 32'd12});
    wait_outputs(NO, -1);
    finish_volume();
    $display("volume after_reset: outputs %0d", n_out_vol);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/forward.md
# conv_3D_asymmetric_input_asymmetric_kernel_module_066

Forward (direct) 3D convolution engine: the data-flow counterpart of the transposed 3D convolution block in the operator library. It loads a KD×KH×KW kernel and a D×H×W input volume, computes the valid (unpadded), strided 3D convolution with one serial multiply-accumulate per cycle, and streams the saturated results out under a valid/ready handshake. The block is single-channel, has no bias, and sits behind the same stream producers as the other operator modules.

## Interface
- D, 4, input depth
- H, 4, input height
- W, 5, input width
- KD, 2, kernel depth (≤ D)
- KH, 3, kernel height (≤ H)
- KW, 2, kernel width (≤ W)
- SD / SH / SW, 1 / 1 / 2, strides
- Derived values:
  - OD = (D−KD)/SD+1, OH = (H−KH)/SH+1, OW = (W−KW)/SW+1, all using floor division.
  - KT = KD·KH·KW; NO = OD·OH·OW.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; asynchronous, active-low.
- weight_valid  in  1  weight word strobe.
- weight_data  in  32  kernel tap; [15:0] is signed, [31:16] is ignored.
- weight_reload  in  1  request to return to weight load.
- valid_in  in  1  input word strobe.
- input_data  in  32  input sample; [15:0] is signed, [31:16] is ignored.
- in_ready  out  1  high in W_LOAD and X_LOAD.
- valid_out  out  1  output word valid.
- ready_out  in  1  downstream accept.
- output_data  out  32  signed, saturated convolution result.
- out_last  out  1  marks the final output of the volume.

## Operation
- States:
  - W_LOAD (entered from reset): each weight_valid accepts one tap into wmem in raster order (kd, kh, kw; kw fastest). After the KT-th tap, go to X_LOAD. valid_in is ignored in this state.
  - X_LOAD: each valid_in accepts one sample into xmem in raster order (d, h, w; w fastest). After the D·H·W-th sample, go to MAC.
    - weight_reload is honored only while the input count is 0: it moves to W_LOAD and clears the weight count.
    - If weight_reload arrives later in X_LOAD, or in any other state, it is ignored.
  - MAC: the accumulator is cleared when MAC is entered. One tap per cycle:
    - acc += x[od·SD+kd][oh·SH+kh][ow·SW+kw] · w[kd][kh][kw]
    - The tap counter runs 0..KT−1; after tap KT−1 the state goes to EMIT.
  - EMIT: valid_out=1, with output_data and out_last held stable until ready_out=1.
    - On handshake, if this was not the last output: advance (ow fastest, then oh, then od) and return to MAC.
    - On handshake after the last output: go to X_LOAD. Weights are retained; the input count is cleared.
- Arithmetic:
  - Product: 16×16 signed → 32-bit.
  - Accumulator: 40-bit signed (no overflow for KT ≤ 256).
  - Output: the accumulator saturated to signed 32-bit (>0x7FFFFFFF → 0x7FFFFFFF; <−2^31 → 0x80000000).
- Memory reads are combinational from register arrays; the address is formed from the output and kernel counters.
- out_last = 1 only in EMIT for output index NO−1.

## Timing
- Reset values:
  - state = W_LOAD; all counters and the accumulator = 0.
  - valid_out = 0, output_data = 0, out_last = 0, in_ready = 1.
  - Memory contents are undefined.
- Reset asserted mid-operation aborts immediately to the reset values. Any partial weights or inputs must be reloaded.
- Accept rule: a word is accepted in a cycle with strobe=1 and in_ready=1. A strobe for the other memory type is dropped.
- Latency:
  - The last input is accepted at edge t. MAC occupies cycles t+1..t+KT, and valid_out rises in cycle t+KT+1.
  - Each subsequent output takes KT cycles of MAC after the prior handshake, so the minimum output period is KT+1 cycles.
- in_ready falls the cycle after the last input is accepted, and rises the cycle after the final output handshake.
- ready_out is ignored outside EMIT. valid_out never depends combinationally on ready_out.

## Test plan
- Defaults, all taps 1, all inputs 1 → 12 outputs, each 12 (0x0000000C); out_last asserted only on the 12th output; first valid_out arrives 13 cycles after the last input is accepted.
- Identity kernel (w[0]=1, others 0), x[i]=i → outputs in order 0, 2, 5, 7, 20, 22, 25, 27, 40, 42, 45, 47.
- Saturation:
  - All inputs 0x7FFF, all taps 0x7FFF → every output 0x7FFFFFFF.
  - All inputs 0x8000, all taps 0x7FFF → every output 0x80000000.
- Backpressure: hold ready_out=0 for 5 cycles during EMIT → output_data and out_last stay stable; the next output appears exactly 12 MAC cycles after the handshake.
- Reuse and reload:
  - A second volume without reloading weights → correct results using the retained kernel.
  - Pulse weight_reload in X_LOAD with 0 inputs loaded → state returns to W_LOAD; a new all-2 kernel with all-1 inputs gives outputs of 24.
- Reset mid-MAC: deassert rst_n during output 3 → valid_out=0 and in_ready=1 immediately; a full reload afterwards reproduces the first scenario's results.
